// File: rtl/ps2_pkg.sv
// ps2_pkg -- shared definitions for the PS/2 letter receiver.
//   KEY_RELEASE / KEY_UNKNOWN : special letter codes (31 / 30)
//   SC_BREAK / SC_EXT         : scan-code-set-2 prefix bytes (0xF0 / 0xE0)
//   frame_state_t             : frame FSM states
//   sc_to_letter()            : scan code -> letter index (A..Z = 0..25)
package ps2_pkg;

    localparam logic [4:0] KEY_RELEASE = 5'd31;
    localparam logic [4:0] KEY_UNKNOWN = 5'd30;
    localparam logic [7:0] SC_BREAK    = 8'hF0;
    localparam logic [7:0] SC_EXT      = 8'hE0;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } frame_state_t;

    function automatic logic [4:0] sc_to_letter(input logic [7:0] sc);
        logic [4:0] l;
        case (sc)
            8'h1C:   l = 5'd0;   // A
            8'h32:   l = 5'd1;   // B
            8'h21:   l = 5'd2;   // C
            8'h23:   l = 5'd3;   // D
            8'h24:   l = 5'd4;   // E
            8'h2B:   l = 5'd5;   // F
            8'h34:   l = 5'd6;   // G
            8'h33:   l = 5'd7;   // H
            8'h43:   l = 5'd8;   // I
            8'h3B:   l = 5'd9;   // J
            8'h42:   l = 5'd10;  // K
            8'h4B:   l = 5'd11;  // L
            8'h3A:   l = 5'd12;  // M
            8'h31:   l = 5'd13;  // N
            8'h44:   l = 5'd14;  // O
            8'h4D:   l = 5'd15;  // P
            8'h15:   l = 5'd16;  // Q
            8'h2D:   l = 5'd17;  // R
            8'h1B:   l = 5'd18;  // S
            8'h2C:   l = 5'd19;  // T
            8'h3C:   l = 5'd20;  // U
            8'h2A:   l = 5'd21;  // V
            8'h1D:   l = 5'd22;  // W
            8'h22:   l = 5'd23;  // X
            8'h35:   l = 5'd24;  // Y
            8'h1A:   l = 5'd25;  // Z
            default: l = KEY_UNKNOWN;
        endcase
        return l;
    endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// ps2_frame_rx -- PS/2 device-to-host frame receiver.
// Synchronizes kbdclk/kbddat, detects kbdclk falling edges and assembles
// start / 8 data (LSB first) / parity / stop frames. A partial frame is
// abandoned after TIMEOUT_CYCLES clocks without a falling edge.
// Build option: define PS2_PARITY_CHECK_EN to reject frames whose data plus
// parity bits have even parity; otherwise the parity bit is ignored.
// Ports:
//   clk, rst_n   : system clock, async active-low reset
//   kbdclk       : raw PS/2 clock (asynchronous)
//   kbddat       : raw PS/2 data (asynchronous)
//   rx_byte      : last assembled byte (valid with byte_valid)
//   byte_valid   : combinational, high in the cycle the stop bit is accepted
//   frame_err    : one-cycle registered pulse on a discarded frame
module ps2_frame_rx
    import ps2_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 2000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       kbdclk,
    input  logic       kbddat,
    output logic [7:0] rx_byte,
    output logic       byte_valid,
    output logic       frame_err
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] TO_MAX = CNT_W'(TIMEOUT_CYCLES);

    logic              clk_meta, clk_sync, clk_prev;
    logic              dat_meta, dat_sync;
    frame_state_t      state;
    logic [7:0]        shift_q;
    logic [2:0]        bit_cnt;
    logic [CNT_W-1:0]  to_cnt;
    logic              fall;
    logic              timeout_hit;
    logic              parity_ok;

`ifdef PS2_PARITY_CHECK_EN
    logic parity_bit;
    // Odd parity over data + parity bit is the only legal frame.
    assign parity_ok = ^{shift_q, parity_bit};
`else
    assign parity_ok = 1'b1;
`endif

    // Synchronized kbdclk went 1 -> 0; the synchronized data is sampled here.
    assign fall        = clk_prev & ~clk_sync;
    // A real edge in the same cycle wins over the timeout.
    assign timeout_hit = !fall && (state != ST_IDLE) && (to_cnt == TO_MAX);
    assign byte_valid  = fall && (state == ST_STOP) && dat_sync && parity_ok;
    assign rx_byte     = shift_q;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_meta <= 1'b1;
            clk_sync <= 1'b1;
            clk_prev <= 1'b1;
            dat_meta <= 1'b1;
            dat_sync <= 1'b1;
        end else begin
            clk_meta <= kbdclk;
            clk_sync <= clk_meta;
            clk_prev <= clk_sync;
            dat_meta <= kbddat;
            dat_sync <= dat_meta;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            shift_q   <= 8'h00;
            bit_cnt   <= 3'd0;
            to_cnt    <= '0;
            frame_err <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
            parity_bit <= 1'b0;
`endif
        end else begin
            frame_err <= 1'b0;

            if (fall || state == ST_IDLE) begin
                to_cnt <= '0;
            end else begin
                to_cnt <= to_cnt + CNT_W'(1);
            end

            if (timeout_hit) begin
                state     <= ST_IDLE;
                frame_err <= 1'b1;
            end else if (fall) begin
                case (state)
                    ST_IDLE: begin
                        if (!dat_sync) begin
                            state   <= ST_DATA;
                            bit_cnt <= 3'd0;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end
                    ST_DATA: begin
                        shift_q <= {dat_sync, shift_q[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            state <= ST_PARITY;
                        end
                    end
                    ST_PARITY: begin
`ifdef PS2_PARITY_CHECK_EN
                        parity_bit <= dat_sync;
`endif
                        state <= ST_STOP;
                    end
                    ST_STOP: begin
                        state <= ST_IDLE;
                        if (!byte_valid) begin
                            frame_err <= 1'b1;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: rtl/ps2_letter_rx.sv
// ps2_letter_rx -- PS/2 keyboard receiver that reports letter key events.
// Bytes from ps2_frame_rx go through break (0xF0) / extended (0xE0) prefix
// handling and scan-code-set-2 translation. Build option
// PS2_PARITY_CHECK_EN enables parity rejection inside the frame receiver.
// Ports:
//   clk, rst_n    : 100 MHz system clock, async active-low reset
//   kbdclk        : raw PS/2 clock (asynchronous)
//   kbddat        : raw PS/2 data (asynchronous)
//   letter        : last event, A..Z = 0..25, 30 unknown, 31 release; held
//   letter_valid  : one-cycle pulse when letter updates
//   frame_err     : one-cycle pulse on a discarded frame
module ps2_letter_rx
    import ps2_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 2000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       kbdclk,
    input  logic       kbddat,
    output logic [4:0] letter,
    output logic       letter_valid,
    output logic       frame_err
);

    logic [7:0] rx_byte;
    logic       byte_valid;
    logic       break_pending;
    logic       ext_pending;

    ps2_frame_rx #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_frame_rx (
        .clk       (clk),
        .rst_n     (rst_n),
        .kbdclk    (kbdclk),
        .kbddat    (kbddat),
        .rx_byte   (rx_byte),
        .byte_valid(byte_valid),
        .frame_err (frame_err)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            letter        <= KEY_RELEASE;
            letter_valid  <= 1'b0;
            break_pending <= 1'b0;
            ext_pending   <= 1'b0;
        end else begin
            letter_valid <= 1'b0;
            if (byte_valid) begin
                if (rx_byte == SC_BREAK) begin
                    break_pending <= 1'b1;
                end else if (rx_byte == SC_EXT) begin
                    ext_pending <= 1'b1;
                end else if (ext_pending) begin
                    // Extended keys are never letters: swallow make and break.
                    ext_pending   <= 1'b0;
                    break_pending <= 1'b0;
                end else if (break_pending) begin
                    letter        <= KEY_RELEASE;
                    letter_valid  <= 1'b1;
                    break_pending <= 1'b0;
                end else begin
                    letter       <= sc_to_letter(rx_byte);
                    letter_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_ps2_letter_rx.sv
// tb_ps2_letter_rx -- self-checking bench for ps2_letter_rx.
// Drives PS/2 frames bit by bit; a behavioural model predicts each event
// (letter pulse or frame error) and the cycle it must appear in, and a
// monitor compares the DUT against that prediction on every clock.
`timescale 1ns/1ps
module tb_ps2_letter_rx;

    localparam int TO   = 300;
    localparam int HALF = 8;
`ifdef PS2_PARITY_CHECK_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic       clk    = 1'b0;
    logic       rst_n  = 1'b1;
    logic       kbdclk = 1'b1;
    logic       kbddat = 1'b1;
    logic [4:0] letter;
    logic       letter_valid;
    logic       frame_err;

    always #5 clk = ~clk;

    ps2_letter_rx #(
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .kbdclk      (kbdclk),
        .kbddat      (kbddat),
        .letter      (letter),
        .letter_valid(letter_valid),
        .frame_err   (frame_err)
    );

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int lv_count    = 0;
    int fe_count    = 0;
    int last_edge   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         at;
        bit         is_err;
        logic [4:0] letter;
    } exp_t;

    exp_t       expq[$];
    logic [4:0] model_letter = 5'd31;
    bit         m_break      = 1'b0;
    bit         m_ext        = 1'b0;

    logic [7:0] sc_tab [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34,
                                8'h33, 8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31,
                                8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C,
                                8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, got, want);
        end
    endtask

    function automatic logic [4:0] lookup(input logic [7:0] b);
        for (int i = 0; i < 26; i++) begin
            if (sc_tab[i] == b) return 5'(i);
        end
        return 5'd30;
    endfunction

    task automatic push_err(input int at);
        exp_t e;
        e.at = at; e.is_err = 1'b1; e.letter = 5'd0;
        expq.push_back(e);
    endtask

    // Prefix/translation rules applied to one accepted byte.
    task automatic model_byte(input logic [7:0] b, input int at);
        exp_t e;
        e.at = at; e.is_err = 1'b0;
        if (b == 8'hF0) begin
            m_break = 1'b1;
        end else if (b == 8'hE0) begin
            m_ext = 1'b1;
        end else if (m_ext) begin
            m_ext = 1'b0; m_break = 1'b0;
        end else if (m_break) begin
            m_break = 1'b0; e.letter = 5'd31; expq.push_back(e);
        end else begin
            e.letter = lookup(b); expq.push_back(e);
        end
    endtask

    // Monitor: every cycle, pulses must match the head of the prediction queue.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (expq.size() > 0 && expq[0].at == cyc) begin
                e = expq.pop_front();
                if (e.is_err) begin
                    check("frame_err_expected", frame_err, 1);
                    check("letter_valid_with_err", letter_valid, 0);
                end else begin
                    check("letter_valid_expected", letter_valid, 1);
                    check("frame_err_with_letter", frame_err, 0);
                    model_letter = e.letter;
                end
            end else begin
                check("letter_valid_spurious", letter_valid, 0);
                check("frame_err_spurious", frame_err, 0);
            end
            check("letter_value", letter, model_letter);
            if (letter_valid) lv_count++;
            if (frame_err) fe_count++;
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk);
    endtask

    // act: 0 = no event, 1 = frame error, 2 = byte d accepted at this edge.
    // Events appear 3 clocks after the raw edge: 2 sync flops + 1 register.
    task automatic send_bit(input logic b, input int act, input logic [7:0] d);
        kbddat = b;
        wait_neg(HALF);
        kbdclk = 1'b0;
        last_edge = cyc;
        if (act == 1) push_err(cyc + 3);
        else if (act == 2) model_byte(d, cyc + 3);
        wait_neg(HALF);
        kbdclk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] d, input bit par_bad, input bit stop_bad);
        logic p;
        int   act;
        p = ~(^d) ^ par_bad;
        send_bit(1'b0, 0, 8'h00);
        for (int i = 0; i < 8; i++) send_bit(d[i], 0, 8'h00);
        send_bit(p, 0, 8'h00);
        act = (stop_bad || (par_bad && PAR_EN)) ? 1 : 2;
        send_bit(~stop_bad, act, d);
        kbddat = 1'b1;
        wait_neg(20);
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        expq.delete();
        model_letter = 5'd31;
        m_break = 1'b0;
        m_ext   = 1'b0;
        kbdclk  = 1'b1;
        kbddat  = 1'b1;
        wait_neg(n);
        rst_n = 1'b1;
        wait_neg(5);
    endtask

    initial begin
        int lv0, fe0;
        #2;
        rst_n = 1'b0;
        @(negedge clk);
        check("reset_letter", letter, 31);
        check("reset_letter_valid", letter_valid, 0);
        check("reset_frame_err", frame_err, 0);
        do_reset(4);

        // Plain make code for A.
        lv0 = lv_count;
        send_frame(8'h1C, 1'b0, 1'b0);
        check("a_pulse_count", lv_count - lv0, 1);
        check("a_letter", letter, 0);

        // Break prefix then A: one release event only.
        lv0 = lv_count;
        send_frame(8'hF0, 1'b0, 1'b0);
        check("break_prefix_no_pulse", lv_count - lv0, 0);
        send_frame(8'h1C, 1'b0, 1'b0);
        check("release_pulse_count", lv_count - lv0, 1);
        check("release_letter", letter, 31);

        // Inverted parity.
        lv0 = lv_count; fe0 = fe_count;
        send_frame(8'h1C, 1'b1, 1'b0);
`ifdef PS2_PARITY_CHECK_EN
        check("parity_err_count", fe_count - fe0, 1);
        check("parity_err_no_letter", lv_count - lv0, 0);
        check("parity_err_letter_held", letter, 31);
`else
        check("parity_ignored_count", lv_count - lv0, 1);
        check("parity_ignored_letter", letter, 0);
`endif

        // Extended key is swallowed, next letter V comes through.
        lv0 = lv_count;
        send_frame(8'hE0, 1'b0, 1'b0);
        send_frame(8'h75, 1'b0, 1'b0);
        send_frame(8'h2A, 1'b0, 1'b0);
        check("ext_pulse_count", lv_count - lv0, 1);
        check("ext_then_v_letter", letter, 21);

        // Timeout after 5 bits, then Z.
        fe0 = fe_count;
        send_bit(1'b0, 0, 8'h00);
        for (int i = 0; i < 4; i++) send_bit(1'($urandom_range(0, 1)), 0, 8'h00);
        push_err(last_edge + 3 + TO + 1);
        kbddat = 1'b1;
        wait_neg(TO + 10);
        check("timeout_err_count", fe_count - fe0, 1);
        send_frame(8'h1A, 1'b0, 1'b0);
        check("after_timeout_letter", letter, 25);

        // Reset in the middle of a frame, then B.
        lv0 = lv_count; fe0 = fe_count;
        send_bit(1'b0, 0, 8'h00);
        for (int i = 0; i < 3; i++) send_bit(1'b1, 0, 8'h00);
        do_reset(3);
        check("midreset_letter", letter, 31);
        check("midreset_no_letter_pulse", lv_count - lv0, 0);
        check("midreset_no_err_pulse", fe_count - fe0, 0);
        send_frame(8'h32, 1'b0, 1'b0);
        check("after_reset_letter", letter, 1);

        // Auto-repeat then release: three A events, one release.
        lv0 = lv_count;
        for (int i = 0; i < 3; i++) send_frame(8'h1C, 1'b0, 1'b0);
        send_frame(8'hF0, 1'b0, 1'b0);
        send_frame(8'h1C, 1'b0, 1'b0);
        check("autorepeat_pulse_count", lv_count - lv0, 4);
        check("autorepeat_release_letter", letter, 31);

        // Bad start bit and bad stop bit.
        fe0 = fe_count;
        send_bit(1'b1, 1, 8'h00);
        wait_neg(20);
        send_frame(8'h24, 1'b0, 1'b1);
        check("start_stop_err_count", fe_count - fe0, 2);
        check("stop_err_letter_held", letter, 31);

        // Unmapped byte.
        send_frame(8'h16, 1'b0, 1'b0);
        check("unknown_letter", letter, 30);

        // Randomized traffic.
        for (int n = 0; n < 60; n++) begin
            int         r;
            logic [7:0] b;
            r = $urandom_range(0, 9);
            if (r == 0) begin
                send_bit(1'b1, 1, 8'h00);
                wait_neg(20);
            end else begin
                r = $urandom_range(0, 7);
                if (r <= 4) b = sc_tab[$urandom_range(0, 25)];
                else if (r == 5) b = 8'hF0;
                else if (r == 6) b = 8'hE0;
                else b = 8'($urandom_range(0, 255));
                send_frame(b, $urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0);
            end
            wait_neg($urandom_range(2, 30));
        end

        wait_neg(20);
        check("prediction_queue_drained", expq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ps2_letter_rx.md
PS2_LETTER_RX -- requirements
Module: ps2_letter_rx

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; ports clk and rst_n, all logic on posedge clk.
REQ-002 Parameter TIMEOUT_CYCLES, default 2000000: clk cycles without a kbdclk falling edge before a partial frame is abandoned.
REQ-003 Port: clk  input  1  system clock, 100 MHz.
REQ-004 Port: rst_n  input  1  asynchronous active-low reset.
REQ-005 Port: kbdclk  input  1  raw PS/2 clock from the keyboard, asynchronous.
REQ-006 Port: kbddat  input  1  raw PS/2 data from the keyboard, asynchronous.
REQ-007 Port: letter  output  5  last decoded event: A..Z = 0..25, KEY_UNKNOWN = 30, KEY_RELEASE = 31; held between events.
REQ-008 Port: letter_valid  output  1  one-cycle pulse when letter is updated.
REQ-009 Port: frame_err  output  1  one-cycle pulse on a discarded frame (bad start/stop bit, bad parity, timeout).

Function
REQ-010 kbdclk and kbddat SHALL each pass through a 2-flop synchronizer; a falling edge SHALL be a 1-to-0 transition of synchronized kbdclk, and data SHALL be sampled in that cycle.
REQ-011 Frame FSM states SHALL be IDLE, DATA, PARITY, STOP.
REQ-012 IDLE: on a falling edge with data 0 go to DATA; with data 1 pulse frame_err and stay in IDLE.
REQ-013 DATA: shift 8 bits LSB first, 3-bit counter; after bit 7 go to PARITY.
REQ-014 PARITY: capture the bit and go to STOP.
REQ-015 STOP: data 1 makes the byte accepted; data 0 pulses frame_err and discards the byte; in both cases return to IDLE.
REQ-016 A timeout counter SHALL clear on every falling edge and increment in non-IDLE states.
REQ-017 When the timeout counter reaches TIMEOUT_CYCLES, the FSM SHALL return to IDLE and pulse frame_err; bits already collected are discarded.
REQ-018 Byte processing SHALL be as follows:
  - 0xF0 sets break_pending.
  - 0xE0 sets ext_pending.
  - Any other byte with ext_pending set is dropped and clears both flags.
  - Any other byte with break_pending set gives letter=31 and clears the flag.
  - Otherwise the byte is translated via the scan-code-set-2 table (0x1C->0, 0x32->1 ... 0x1A->25); unmapped bytes give 30.
REQ-019 letter and letter_valid SHALL update together in the cycle after the STOP sample (latency 1 clk from the accepting falling edge).
REQ-020 Prefix bytes (0xF0, 0xE0) SHALL never assert letter_valid.
REQ-021 A key release SHALL produce exactly one KEY_RELEASE event, including auto-repeat sequences.
REQ-022 letter_valid and frame_err SHALL never assert in the same cycle.

Reset
REQ-023 On rst_n low: FSM=IDLE, letter=31, letter_valid=0, frame_err=0; break_pending, ext_pending, shift register, bit counter, timeout counter and synchronizers (to 1) cleared.
REQ-024 Reset mid-frame SHALL discard the partial frame without a frame_err pulse.

Configuration
REQ-025 With PS2_PARITY_CHECK_EN defined, a byte whose 8 data bits plus parity bit have even parity SHALL be discarded with frame_err.
REQ-026 Without PS2_PARITY_CHECK_EN, the parity bit SHALL be sampled and ignored.

Structure
REQ-027 Package ps2_pkg SHALL hold: KEY_RELEASE=31, KEY_UNKNOWN=30, SC_BREAK=8'hF0, SC_EXT=8'hE0, the FSM state enum, and the 26-entry scan-code-to-letter table function.
REQ-028 Sub-module ps2_frame_rx SHALL contain the synchronizers, frame FSM and timeout, and emit byte and byte_valid.
REQ-029 The top level SHALL hold the prefix logic and translation.

Verification
REQ-030 Frame 0x1C with correct odd parity -> one letter_valid pulse, letter=0.
REQ-031 Frames 0xF0, 0x1C -> exactly one letter_valid, letter=31, none for 0xF0.
REQ-032 Frames 0xE0, 0x75 then 0x2A -> only one letter_valid, letter=21.
REQ-033 Frame 0x1C with parity bit inverted -> frame_err pulse, no letter_valid with the macro; letter=0 pulse without it.
REQ-034 5 bits sent, then idle TIMEOUT_CYCLES+10 clks -> one frame_err pulse; next frame 0x1A -> letter=25.
REQ-035 rst_n pulsed low after 4 bits -> letter=31, no pulses; next frame 0x32 -> letter=1.
